fifo_read_stream_adapter: RTL and testbench

- Drains the read side of the async circular FIFO and presents its words on a valid/ready stream.
- Lives entirely in the read clock domain; it is the consumer end of the FIFO read interface (read strobe, empty flag, read data).
- FIFO read data arrives one cycle after the read strobe. A 2-entry skid buffer absorbs that latency, so the stream runs at one word per cycle under continuous ready and never loses data under backpressure.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/skid_buffer_2.sv | 56 +++++
 rtl/fifo_read_stream_adapter.sv | 71 +++++++
 tb/tb_fifo_read_stream_adapter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing constants for the FIFO read-side skid buffer.
package fifo_pkg;

  // Depth of the skid buffer: one word landing from the FIFO plus one held
  // under backpressure.
  localparam int SKID_ENTRIES = 2;

  // Occupancy counts 0..SKID_ENTRIES inclusive.
  localparam int OCC_W = $clog2(SKID_ENTRIES + 1);

  // Index into the skid storage.
  localparam int IDX_W = (SKID_ENTRIES > 1) ? $clog2(SKID_ENTRIES) : 1;

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry circular skid buffer: captures FIFO read data and presents the
// oldest word; flush empties it and realigns both indices to zero.
module skid_buffer_2
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] mem [SKID_ENTRIES];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  // Storage, indices and occupancy; the indices wrap naturally because the
  // entry count is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_ENTRIES; i++) begin
        mem[i] <= '0;
      end
      wr_idx <= '0;
      rd_idx <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_idx <= '0;
      rd_idx <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= wr_idx + IDX_W'(1);
      end
      if (pop) begin
        rd_idx <= rd_idx + IDX_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign valid = (occ != '0);
  assign data  = mem[rd_idx];

endmodule

// File: rtl/fifo_read_stream_adapter.sv
// Consumer end of the async FIFO read port: issues read strobes, absorbs the
// one-cycle read-data latency in a 2-entry skid buffer and presents the words
// on a valid/ready stream, counting every accepted word.
module fifo_read_stream_adapter
  import fifo_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   nrst_in,
  input  logic                   fifo_empty_in,
  input  logic [WIDTH-1:0]       fifo_data_in,
  output logic                   fifo_read_out,
  input  logic                   flush_in,
  output logic                   m_valid_out,
  input  logic                   m_ready_in,
  output logic [WIDTH-1:0]       m_data_out,
  output logic [COUNT_WIDTH-1:0] words_out
);

  localparam int SUM_W = OCC_W + 1;

  logic             run;
  logic             inflight;
  logic             pop;
  logic             room;
  logic [OCC_W-1:0] occ;
  logic [SUM_W-1:0] committed;

  assign pop = m_valid_out & m_ready_in;

  // Words already owed to the buffer: held entries plus the one in flight.
  // A pop this cycle frees a slot in time for a word issued now, so ready
  // feeds straight into the strobe and full rate survives continuous ready.
  assign committed = SUM_W'(occ) + SUM_W'(inflight);
  assign room      = committed < (SUM_W'(SKID_ENTRIES) + SUM_W'(pop));

  assign fifo_read_out = run & ~fifo_empty_in & ~flush_in & room;

  // Run flag, in-flight tracking and accepted-word counter. The strobe is
  // already low during a flush, so inflight clears on its own.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      run       <= 1'b0;
      inflight  <= 1'b0;
      words_out <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= fifo_read_out;
      if (pop && !flush_in) begin
        words_out <= words_out + COUNT_WIDTH'(1);
      end
    end
  end

  skid_buffer_2 #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk       (clk_in),
    .rst_n     (nrst_in),
    .flush     (flush_in),
    .push      (inflight & ~flush_in),
    .push_data (fifo_data_in),
    .pop       (pop),
    .occ       (occ),
    .valid     (m_valid_out),
    .data      (m_data_out)
  );

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Directed bench for fifo_read_stream_adapter with a small FIFO read-port model.
module tb_fifo_read_stream_adapter;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk_in = 1'b0;
  logic             nrst_in = 1'b0;
  logic             fifo_empty_in;
  logic [WIDTH-1:0] fifo_data_in;
  logic             fifo_read_out;
  logic             flush_in = 1'b0;
  logic             m_valid_out;
  logic             m_ready_in = 1'b0;
  logic [WIDTH-1:0] m_data_out;
  logic [CW-1:0]    words_out;

  logic [WIDTH-1:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int total  = 0;
  int bad    = 0;

  fifo_read_stream_adapter #(
    .WIDTH       (WIDTH),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk_in        (clk_in),
    .nrst_in       (nrst_in),
    .fifo_empty_in (fifo_empty_in),
    .fifo_data_in  (fifo_data_in),
    .fifo_read_out (fifo_read_out),
    .flush_in      (flush_in),
    .m_valid_out   (m_valid_out),
    .m_ready_in    (m_ready_in),
    .m_data_out    (m_data_out),
    .words_out     (words_out)
  );

  always #5 clk_in = ~clk_in;

  // FIFO read port: data appears the cycle after the strobe.
  assign fifo_empty_in = (rd_ptr == wr_ptr);
  always @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      rd_ptr       <= 0;
      fifo_data_in <= '0;
    end else if (fifo_read_out) begin
      fifo_data_in <= mem[rd_ptr[5:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] base, input int n);
    nrst_in    = 1'b0;
    m_ready_in = 1'b0;
    flush_in   = 1'b0;
    for (int i = 0; i < n; i++) mem[i] = base + 8'(i);
    wr_ptr = n;
    #1;
    chk("rst_rd", fifo_read_out, 0);
    chk("rst_vld", m_valid_out, 0);
    chk("rst_words", words_out, 0);
    repeat (2) @(posedge clk_in);
    #1 nrst_in = 1'b1;
    @(negedge clk_in);
    chk("run_gate_rd", fifo_read_out, 0);
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset, then plain streaming of 0x10..0x17.
    do_reset(8'h10, 8);
    m_ready_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_in);
      chk("t1_rd", fifo_read_out, (k < 8));
      chk("t1_vld", m_valid_out, (k >= 2 && k < 10));
      if (k >= 2 && k < 10) chk("t1_data", m_data_out, 32'h10 + k - 2);
      @(posedge clk_in);
      #1;
    end
    chk("t1_words", words_out, 8);

    // Backpressure: ready low for four cycles mid-stream.
    do_reset(8'h20, 8);
    for (int k = 0; k < 15; k++) begin
      m_ready_in = !(k >= 4 && k <= 7);
      @(negedge clk_in);
      chk("t2_rd", fifo_read_out, (k <= 3 || (k >= 8 && k <= 11)));
      chk("t2_vld", m_valid_out, (k >= 2 && k <= 13));
      if (k >= 2 && k <= 3)  chk("t2_data", m_data_out, 32'h20 + k - 2);
      if (k >= 4 && k <= 8)  chk("t2_hold", m_data_out, 32'h22);
      if (k >= 9 && k <= 13) chk("t2_data", m_data_out, 32'h20 + k - 6);
      @(posedge clk_in);
      #1;
    end
    chk("t2_words", words_out, 8);

    // Flush with one word held, one in flight, and a pop in the flush cycle.
    do_reset(8'h30, 8);
    m_ready_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      flush_in = (k == 4);
      @(negedge clk_in);
      chk("t3_rd", fifo_read_out, (k <= 3 || (k >= 5 && k <= 8)));
      chk("t3_vld", m_valid_out, ((k >= 2 && k <= 4) || (k >= 7 && k <= 10)));
      if (k >= 2 && k <= 4)  chk("t3_data", m_data_out, 32'h30 + k - 2);
      if (k >= 7 && k <= 10) chk("t3_data", m_data_out, 32'h34 + k - 7);
      if (k == 5) chk("t3_words_flush", words_out, 2);
      @(posedge clk_in);
      #1;
    end
    flush_in = 1'b0;
    chk("t3_words", words_out, 6);

    // Counter wrap: 17 pops on a 4-bit counter.
    do_reset(8'h40, 17);
    m_ready_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      chk("t4_rd", fifo_read_out, (k <= 16));
      if (k >= 2 && k <= 18) chk("t4_data", m_data_out, 32'h40 + k - 2);
      if (k == 17) chk("t4_words_15", words_out, 15);
      if (k == 18) chk("t4_words_0", words_out, 0);
      if (k == 19) chk("t4_words_1", words_out, 1);
      @(posedge clk_in);
      #1;
    end

    // Asynchronous reset between edges with the buffer full.
    do_reset(8'h50, 8);
    for (int k = 0; k < 6; k++) begin
      m_ready_in = (k <= 3);
      @(negedge clk_in);
      if (k == 5) begin
        chk("t5_vld_pre", m_valid_out, 1);
        chk("t5_data_pre", m_data_out, 32'h52);
        chk("t5_words_pre", words_out, 2);
      end
      if (k < 5) begin
        @(posedge clk_in);
        #1;
      end
    end
    #2 nrst_in = 1'b0;
    #1;
    chk("t5_vld_rst", m_valid_out, 0);
    chk("t5_words_rst", words_out, 0);
    chk("t5_rd_rst", fifo_read_out, 0);
    chk("t5_data_rst", m_data_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
